// File: rtl/fpu_forward_ctrl.sv
// FPU operand-stage forwarding and hazard control: tracks in-flight destinations
// over MAX_LAT slots and produces youngest-match forward selects plus issue stall.
module fpu_forward_ctrl #(
  parameter int REG_W   = 5,
  parameter int MAX_LAT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               issue_valid,
  input  logic               issue_wen,
  input  logic [REG_W-1:0]   issue_rd,
  input  logic [2:0]         issue_lat,
  input  logic [REG_W-1:0]   rs_a,
  input  logic [REG_W-1:0]   rs_b,
  input  logic               rs_a_use,
  input  logic               rs_b_use,
  output logic               stall,
  output logic [MAX_LAT-1:0] use_a,
  output logic [MAX_LAT-1:0] use_b
);

  // Index k holds the instruction accepted k+1 cycles ago (slot k+1).
  logic [MAX_LAT-1:0] slot_valid;
  logic [REG_W-1:0]   slot_rd  [MAX_LAT];
  logic [2:0]         slot_lat [MAX_LAT];

  logic [MAX_LAT-1:0] hit_a, hit_b, ready;
  logic [2:0]         lat_in;
  logic               accept;

  always_comb begin
    lat_in = issue_lat;
    if (issue_lat == 3'd0)
      lat_in = 3'd1;
    else if (issue_lat > 3'(MAX_LAT))
      lat_in = 3'(MAX_LAT);
  end

  always_comb begin
    hit_a = '0;
    hit_b = '0;
    ready = '0;
    for (int unsigned k = 0; k < MAX_LAT; k++) begin
      hit_a[k] = slot_valid[k] && (slot_rd[k] == rs_a) && rs_a_use;
      hit_b[k] = slot_valid[k] && (slot_rd[k] == rs_b) && rs_b_use;
      ready[k] = (3'(k + 1) >= slot_lat[k]);
    end
  end

  // Lowest set bit is the youngest producer; older matches are stale.
  assign use_a  = hit_a & (~hit_a + MAX_LAT'(1));
  assign use_b  = hit_b & (~hit_b + MAX_LAT'(1));
  assign stall  = issue_valid && ((|(use_a & ~ready)) || (|(use_b & ~ready)));
  assign accept = issue_valid && !stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_valid <= '0;
      for (int unsigned k = 0; k < MAX_LAT; k++) begin
        slot_rd[k]  <= '0;
        slot_lat[k] <= 3'd1;
      end
    end else begin
      for (int unsigned k = 1; k < MAX_LAT; k++) begin
        slot_valid[k] <= slot_valid[k-1];
        slot_rd[k]    <= slot_rd[k-1];
        slot_lat[k]   <= slot_lat[k-1];
      end
      slot_valid[0] <= accept && issue_wen;
      slot_rd[0]    <= issue_rd;
      slot_lat[0]   <= lat_in;
    end
  end

endmodule

// File: tb/tb_fpu_forward_ctrl.sv
// Scoreboard bench for fpu_forward_ctrl: driver queues hand-computed expectations,
// a negedge monitor pops and compares them against stall/use_a/use_b.
module tb_fpu_forward_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       issue_valid = 1'b0, issue_wen = 1'b0;
  logic [4:0] issue_rd = '0, rs_a = '0, rs_b = '0;
  logic [2:0] issue_lat = 3'd1;
  logic       rs_a_use = 1'b0, rs_b_use = 1'b0;
  logic       stall;
  logic [3:0] use_a, use_b;

  typedef struct {
    logic       st;
    logic [3:0] ua;
    logic [3:0] ub;
    string      nm;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  fpu_forward_ctrl #(.REG_W(5), .MAX_LAT(4)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_wen(issue_wen),
    .issue_rd(issue_rd), .issue_lat(issue_lat),
    .rs_a(rs_a), .rs_b(rs_b), .rs_a_use(rs_a_use), .rs_b_use(rs_b_use),
    .stall(stall), .use_a(use_a), .use_b(use_b)
  );

  // Monitor: outputs are presented every cycle; compare mid-cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (stall !== e.st || use_a !== e.ua || use_b !== e.ub) begin
        errors++;
        $display("FAIL %s: got stall=%b use_a=%b use_b=%b, expected stall=%b use_a=%b use_b=%b",
                 e.nm, stall, use_a, use_b, e.st, e.ua, e.ub);
      end
    end
  end

  task automatic step(input logic r, input logic iv, input logic wen,
                      input logic [4:0] rd, input logic [2:0] lat,
                      input logic [4:0] ra, input logic rau,
                      input logic [4:0] rb, input logic rbu,
                      input logic es, input logic [3:0] eua, input logic [3:0] eub,
                      input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; issue_valid = iv; issue_wen = wen; issue_rd = rd; issue_lat = lat;
    rs_a = ra; rs_a_use = rau; rs_b = rb; rs_b_use = rbu;
    e.st = es; e.ua = eua; e.ub = eub; e.nm = nm;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(0, 0, 0, 5'd0, 3'd1, 5'd0, 0, 5'd0, 0, 0, 4'b0000, 4'b0000, "idle");
  endtask

  initial begin
    // Reset holds slots empty even with a writing, reading instruction presented.
    step(1, 1, 1, 5'd3, 3'd1, 5'd3, 1, 5'd0, 0, 0, 4'b0000, 4'b0000, "reset_a");
    step(1, 1, 1, 5'd3, 3'd1, 5'd3, 1, 5'd0, 0, 0, 4'b0000, 4'b0000, "reset_b");
    step(0, 1, 1, 5'd3, 3'd1, 5'd0, 0, 5'd0, 0, 0, 4'b0000, 4'b0000, "first_issue");
    step(0, 1, 0, 5'd0, 3'd1, 5'd3, 1, 5'd0, 0, 0, 4'b0001, 4'b0000, "fwd_slot1");
    idle(4);

    // Latency-3 producer read by operand B.
    step(0, 1, 1, 5'd7, 3'd3, 5'd0, 0, 5'd0, 0, 0, 4'b0000, 4'b0000, "lat3_issue");
    step(0, 1, 1, 5'd8, 3'd1, 5'd0, 0, 5'd7, 1, 1, 4'b0000, 4'b0001, "lat3_s1");
    step(0, 1, 1, 5'd8, 3'd1, 5'd0, 0, 5'd7, 1, 1, 4'b0000, 4'b0010, "lat3_s2");
    step(0, 1, 1, 5'd8, 3'd1, 5'd0, 0, 5'd7, 1, 0, 4'b0000, 4'b0100, "lat3_s3");
    step(0, 0, 0, 5'd0, 3'd1, 5'd0, 0, 5'd8, 1, 0, 4'b0000, 4'b0001, "lat3_accepted");
    idle(4);

    // Younger unready write to rd 5 shadows an older ready one.
    step(0, 1, 1, 5'd5, 3'd1, 5'd0, 0, 5'd0, 0, 0, 4'b0000, 4'b0000, "shadow_old");
    step(0, 1, 1, 5'd5, 3'd4, 5'd0, 0, 5'd0, 0, 0, 4'b0000, 4'b0000, "shadow_new");
    step(0, 1, 0, 5'd0, 3'd1, 5'd5, 1, 5'd0, 0, 1, 4'b0001, 4'b0000, "shadow_s1");
    step(0, 1, 0, 5'd0, 3'd1, 5'd5, 1, 5'd0, 0, 1, 4'b0010, 4'b0000, "shadow_s2");
    step(0, 1, 0, 5'd0, 3'd1, 5'd5, 1, 5'd0, 0, 1, 4'b0100, 4'b0000, "shadow_s3");
    step(0, 1, 0, 5'd0, 3'd1, 5'd5, 1, 5'd0, 0, 0, 4'b1000, 4'b0000, "shadow_s4");
    idle(4);

    // Both operands, distinct producers, then the same register on both.
    step(0, 1, 1, 5'd2, 3'd1, 5'd0, 0, 5'd0, 0, 0, 4'b0000, 4'b0000, "dual_rd2");
    step(0, 1, 1, 5'd9, 3'd1, 5'd0, 0, 5'd0, 0, 0, 4'b0000, 4'b0000, "dual_rd9");
    step(0, 1, 0, 5'd0, 3'd1, 5'd2, 1, 5'd9, 1, 0, 4'b0010, 4'b0001, "dual_read");
    step(0, 1, 0, 5'd0, 3'd1, 5'd2, 1, 5'd2, 1, 0, 4'b0100, 4'b0100, "same_src");
    idle(4);

    // Aging through all slots, use qualifiers, then non-writing instruction.
    step(0, 1, 1, 5'd4, 3'd1, 5'd0, 0, 5'd0, 0, 0, 4'b0000, 4'b0000, "age_issue");
    step(0, 1, 0, 5'd0, 3'd1, 5'd4, 0, 5'd4, 0, 0, 4'b0000, 4'b0000, "age_nouse1");
    step(0, 1, 0, 5'd0, 3'd1, 5'd4, 0, 5'd0, 0, 0, 4'b0000, 4'b0000, "age_nouse2");
    step(0, 0, 0, 5'd0, 3'd1, 5'd4, 1, 5'd0, 0, 0, 4'b0100, 4'b0000, "age_s3");
    step(0, 0, 0, 5'd0, 3'd1, 5'd4, 1, 5'd4, 1, 0, 4'b1000, 4'b1000, "age_s4");
    step(0, 0, 0, 5'd0, 3'd1, 5'd4, 1, 5'd4, 1, 0, 4'b0000, 4'b0000, "age_gone");
    step(0, 1, 0, 5'd4, 3'd1, 5'd0, 0, 5'd0, 0, 0, 4'b0000, 4'b0000, "nowen_issue");
    step(0, 1, 0, 5'd0, 3'd1, 5'd4, 1, 5'd0, 0, 0, 4'b0000, 4'b0000, "nowen_read");

    // rd equal to own source: no self-forwarding, visible next cycle.
    step(0, 1, 1, 5'd6, 3'd1, 5'd6, 1, 5'd0, 0, 0, 4'b0000, 4'b0000, "self_issue");
    step(0, 1, 0, 5'd0, 3'd1, 5'd6, 1, 5'd0, 0, 0, 4'b0001, 4'b0000, "self_next");
    idle(4);

    // Latency clamps; an idle cycle mid-wait must not stall.
    step(0, 1, 1, 5'd10, 3'd0, 5'd0, 0, 5'd0, 0, 0, 4'b0000, 4'b0000, "lat0_issue");
    step(0, 1, 0, 5'd0, 3'd1, 5'd10, 1, 5'd0, 0, 0, 4'b0001, 4'b0000, "lat0_read");
    idle(4);
    step(0, 1, 1, 5'd11, 3'd7, 5'd0, 0, 5'd0, 0, 0, 4'b0000, 4'b0000, "lat7_issue");
    step(0, 1, 0, 5'd0, 3'd1, 5'd0, 0, 5'd11, 1, 1, 4'b0000, 4'b0001, "lat7_s1");
    step(0, 0, 0, 5'd0, 3'd1, 5'd0, 0, 5'd11, 1, 0, 4'b0000, 4'b0010, "lat7_novalid");
    step(0, 1, 0, 5'd0, 3'd1, 5'd0, 0, 5'd11, 1, 1, 4'b0000, 4'b0100, "lat7_s3");
    step(0, 1, 0, 5'd0, 3'd1, 5'd0, 0, 5'd11, 1, 0, 4'b0000, 4'b1000, "lat7_s4");
    idle(4);

    // Reset asserted mid-stall clears everything combinationally.
    step(0, 1, 1, 5'd12, 3'd4, 5'd0, 0, 5'd0, 0, 0, 4'b0000, 4'b0000, "mid_issue");
    step(0, 1, 0, 5'd0, 3'd1, 5'd12, 1, 5'd0, 0, 1, 4'b0001, 4'b0000, "mid_stall");
    step(1, 1, 0, 5'd0, 3'd1, 5'd12, 1, 5'd0, 0, 0, 4'b0000, 4'b0000, "mid_reset");
    step(0, 1, 0, 5'd0, 3'd1, 5'd12, 1, 5'd0, 0, 0, 4'b0000, 4'b0000, "post_reset");

    repeat (2) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d unchecked entries, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fpu_forward_ctrl.md
Name: fpu_forward_ctrl

Overview:
- Forwarding and hazard control for the FPU operand stage.
- Tracks the destination register of every in-flight FPU instruction across the 4 forwarding stages.
- For both source operands it generates the one-hot-or-zero select lines (use1..use4) that drive the downstream priority forwarding muxes.
- Stalls issue when the newest producer of a needed register has not yet produced its result.

Parameters:
- REG_W, 5, width of FP register index (32 registers)
- MAX_LAT, 4, largest legal producer latency in stages; equals forwarding depth

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous reset, active-high
- issue_valid  input  1  instruction presented at operand stage this cycle
- issue_wen  input  1  presented instruction writes an FP register
- issue_rd  input  REG_W  destination register of presented instruction
- issue_lat  input  3  stages until its result appears; legal 1..MAX_LAT
- rs_a  input  REG_W  source register, operand A
- rs_b  input  REG_W  source register, operand B
- rs_a_use  input  1  operand A is read by presented instruction
- rs_b_use  input  1  operand B is read by presented instruction
- stall  output  1  presented instruction not accepted this cycle
- use_a  output  4  bit k-1 = useK select for operand A mux
- use_b  output  4  bit k-1 = useK select for operand B mux

Behaviour:
- State: slots 1..4, each holding valid, rd, lat. Slot k is the instruction accepted k cycles ago; forwardK on the mux carries slot k's result.
- Reset (async, rst=1): all slot valid=0. Consequently stall=0, use_a=0, use_b=0 while in reset and on the first cycle after.
- Accept = issue_valid & ~stall.
- Slot shift, every rising edge when not in reset, regardless of stall: slot(k+1) <= slot k for k=1..3. Slot 4 drops out; its result is in the register file from then on.
- Slot 1 load on the same edge:
  - valid = accept & issue_wen
  - rd = issue_rd
  - lat = issue_lat
  - A stall therefore inserts a bubble into slot 1.
- Latency clamp: issue_lat=0 is stored as 1; issue_lat>MAX_LAT is stored as MAX_LAT.
- Hit (combinational, per operand X in {a,b}): hitX_k = slot_k.valid & (slot_k.rd == rs_X) & rs_X_use.
- Select: the youngest hit wins. useX bit k-1 = hitX_k & no hitX_j for j<k. At most one bit is set.
- Readiness: slot k is ready iff k >= slot_k.lat.
- Stall = issue_valid & (a selected slot for A or for B is not ready). Stall is 0 whenever issue_valid=0.
- use_a/use_b are driven from the hit logic even while stalled. The mux output is ignored until stall drops.
- During a stall the producer advances one slot per cycle. Stall clears exactly when that producer reaches slot = its lat. No extra cycle is required.
- rs_a == rs_b is legal; both outputs select the same slot.
- An older match in a ready slot shadowed by a younger unready match still stalls. The older value is stale.
- Back-to-back writes to the same rd: only the youngest is forwarded.
- An instruction whose rd equals its own rs_a forwards from older slots only; its own slot-1 entry is loaded after the decision.
- rst asserted mid-stall: slots clear immediately; stall and use drop combinationally.
- No state besides the slots; all outputs combinational from slots and current inputs.

Test Plan:
- Reset: rst=1 with issue_valid=1, rs_a=3, rs_a_use=1 -> stall=0, use_a=0000.
  - Then release rst and issue wen rd=3 lat=1 -> next cycle rs_a=3 gives use_a=0001, stall=0.
- Latency stall: issue rd=7 lat=3.
  - Next cycle rs_b=7 -> stall=1, use_b=0001.
  - Next cycle -> stall=1, use_b=0010.
  - Following cycle -> stall=0, use_b=0100, accepted.
- Shadowing: issue rd=5 lat=1, then rd=5 lat=4, then read rs_a=5 -> use_a=0001, stall=1.
  - Stall persists 3 cycles; accepted when use_a=1000.
- Dual operand: rd=2 lat=1 in slot 2 and rd=9 lat=1 in slot 1; read rs_a=2, rs_b=9 -> use_a=0010, use_b=0001, stall=0.
- Aging and qualifiers: rd=4 lat=1 aged to slot 4 -> use=1000.
  - One cycle later -> use=0000.
  - With rs_a_use=0 -> use_a=0000 at every age.
  - Same rd with issue_wen=0 -> no slot entry, so use=0000.
- Clamp: issue_lat=0 behaves as lat=1 (no stall when read from slot 1).
  - issue_lat=7 behaves as lat=4 (accepted when the producer reaches slot 4).
